// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared decode types (immediate format select)
package cotm32_pkg;
  localparam int IMM_SEL_W = 4;
  typedef enum logic [IMM_SEL_W-1:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_CI, IMM_CJ
  } imm_ext_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate decode of inst by sel into imm (XLEN) with illegal flag
module imm_decode import cotm32_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ENABLE_C = 0
) (
  input  logic [31:0]     inst,
  input  imm_ext_t        sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic c_en;
  assign c_en = ENABLE_C != 0;
  always_comb begin
    imm = '0;
    illegal = 1'b0;
    case (sel)
      IMM_I:  imm = XLEN'($signed(inst[31:20]));
      IMM_S:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U:  imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      IMM_Z:  imm = XLEN'(inst[19:15]);
      IMM_SH: imm = XLEN == 64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      IMM_CI: begin
        imm = c_en ? XLEN'($signed({inst[12], inst[6:2]})) : '0;
        illegal = !c_en;
      end
      IMM_CJ: begin
        imm = c_en ? XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                    inst[2], inst[11], inst[5:3], 1'b0})) : '0;
        illegal = !c_en;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator, valid/ready in (inst, sel, tag) to valid/ready out (imm, tag, illegal) via output reg + skid entry
module imm_gen_pipe import cotm32_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ENABLE_C = 0,
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  imm_ext_t         i_sel,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } imm_entry_t;
  imm_entry_t dec, out_q, skid_q;
  logic skid_valid, in_fire, out_free;
  imm_decode #(.XLEN(XLEN), .ENABLE_C(ENABLE_C)) u_dec (
    .inst(i_inst), .sel(i_sel), .imm(dec.imm), .illegal(dec.illegal)
  );
  assign dec.tag = i_tag;
  assign o_ready = !skid_valid;
  assign in_fire = i_valid && o_ready;
  assign out_free = !o_valid || i_ready;
  assign o_imm = out_q.imm;
  assign o_tag = out_q.tag;
  assign o_illegal = out_q.illegal;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q <= '0;
      skid_q <= '0;
      o_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q <= skid_q;
        o_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        o_valid <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire) begin
      skid_q <= dec;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving a 32-bit/no-C and a 64-bit/C instance in lockstep
module tb_imm_gen_pipe;
  import cotm32_pkg::*;
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 1;
  logic [31:0] inst = 0;
  imm_ext_t sel = IMM_I;
  logic [7:0] tag = 0;
  logic a_ready, a_valid, a_ill, b_ready, b_valid, b_ill;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic [7:0] a_tag, b_tag;
  typedef struct {
    logic [31:0] a;
    logic al;
    logic [63:0] b;
    logic bl;
    logic [7:0] t;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .ENABLE_C(0), .TAG_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(a_ready), .i_inst(inst),
    .i_sel(sel), .i_tag(tag), .o_valid(a_valid), .i_ready(i_ready), .o_imm(a_imm),
    .o_tag(a_tag), .o_illegal(a_ill)
  );
  imm_gen_pipe #(.XLEN(64), .ENABLE_C(1), .TAG_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready), .i_inst(inst),
    .i_sel(sel), .i_tag(tag), .o_valid(b_valid), .i_ready(i_ready), .o_imm(b_imm),
    .o_tag(b_tag), .o_illegal(b_ill)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic void ref_imm(input logic [31:0] x, input imm_ext_t s, input bit x64,
                                  input bit c, output logic [63:0] v, output logic il);
    v = '0;
    il = 1'b0;
    case (s)
      IMM_I:  v = {{52{x[31]}}, x[31:20]};
      IMM_S:  v = {{52{x[31]}}, x[31:25], x[11:7]};
      IMM_B:  v = {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      IMM_U:  v = {{32{x[31]}}, x[31:12], 12'b0};
      IMM_J:  v = {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      IMM_Z:  v = {59'b0, x[19:15]};
      IMM_SH: v = x64 ? {58'b0, x[25:20]} : {59'b0, x[24:20]};
      IMM_CI: if (c) v = {{58{x[12]}}, x[12], x[6:2]}; else il = 1'b1;
      IMM_CJ: if (c) v = {{52{x[12]}}, x[12], x[8], x[10:9], x[6], x[7], x[2], x[11], x[5:3], 1'b0};
              else il = 1'b1;
      default: il = 1'b1;
    endcase
  endfunction
  task automatic step(output bit acc);
    exp_t e;
    logic [63:0] v;
    logic il;
    acc = i_valid && a_ready;
    chk("a_valid", a_valid, q.size() > 0);
    chk("b_valid", b_valid, q.size() > 0);
    chk("a_ready", a_ready, q.size() < 2);
    chk("b_ready", b_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("a_imm", a_imm, q[0].a);
      chk("a_ill", a_ill, q[0].al);
      chk("a_tag", a_tag, q[0].t);
      chk("b_imm", b_imm, q[0].b);
      chk("b_ill", b_ill, q[0].bl);
      chk("b_tag", b_tag, q[0].t);
      if (i_ready) void'(q.pop_front());
    end
    if (acc) begin
      ref_imm(inst, sel, 1'b0, 1'b0, v, il);
      e.a = v[31:0];
      e.al = il;
      ref_imm(inst, sel, 1'b1, 1'b1, v, il);
      e.b = v;
      e.bl = il;
      e.t = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] x, input imm_ext_t s, input logic [7:0] t);
    bit acc = 0;
    int n = 0;
    inst = x;
    sel = s;
    tag = t;
    i_valid = 1;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    i_valid = 0;
  endtask
  task automatic drain();
    bit acc;
    int n = 0;
    i_valid = 0;
    i_ready = 1;
    while (q.size() > 0 && n < 20) begin
      step(acc);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    step(acc);
  endtask
  initial begin
    bit acc;
    #12;
    chk("rst_valid", a_valid, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_imm", a_imm, 0);
    chk("rst_tag", a_tag, 0);
    chk("rst_ill", a_ill, 0);
    chk("rst_b_imm", b_imm, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    send(32'hFFF00093, IMM_I, 8'h10);
    chk("i_direct", a_imm, 32'hFFFFFFFF);
    send(32'hFE000EE3, IMM_B, 8'h11);
    chk("b_direct", a_imm, 32'hFFFFFFFC);
    send(32'h123450B7, IMM_U, 8'h12);
    chk("u_direct", a_imm, 32'h12345000);
    send(32'h800000B7, IMM_U, 8'h13);
    chk("u64_direct", b_imm, 64'hFFFFFFFF80000000);
    send(32'h000FD073, IMM_Z, 8'h14);
    chk("z64_direct", b_imm, 64'h1F);
    send(32'h000010FD, IMM_CI, 8'h15);
    chk("ci_c1", b_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("ci_c0_imm", a_imm, 0);
    chk("ci_c0_ill", a_ill, 1);
    send(32'h03F00013, IMM_SH, 8'h16);
    send(32'h0000B7FD, IMM_CJ, 8'h17);
    send(32'hDEADBEEF, imm_ext_t'(4'd12), 8'h18);
    chk("undef_ill", b_ill, 1);
    send(32'h8000F0A3, IMM_S, 8'h19);
    send(32'h8010006F, IMM_J, 8'h1A);
    drain();
    i_ready = 0;
    i_valid = 1;
    inst = 32'h00100093;
    sel = IMM_I;
    tag = 1;
    step(acc);
    tag = 2;
    inst = 32'h00200093;
    step(acc);
    chk("bp_skid_ready", a_ready, 0);
    tag = 3;
    inst = 32'h00300093;
    step(acc);
    chk("bp_hold_tag", a_tag, 1);
    chk("bp_tag3_held", acc, 0);
    i_ready = 1;
    for (int n = 0; n < 20 && !acc; n++) step(acc);
    chk("bp_tag3_taken", acc, 1);
    drain();
    for (int n = 0; n < 300; n++) begin
      i_valid = $urandom_range(0, 1);
      i_ready = $urandom_range(0, 3) != 0;
      inst = $urandom;
      sel = imm_ext_t'($urandom_range(0, 10));
      tag = $urandom;
      step(acc);
    end
    drain();
    i_ready = 0;
    i_valid = 1;
    inst = 32'h00500093;
    tag = 8'hA0;
    step(acc);
    tag = 8'hA1;
    step(acc);
    chk("pre_rst_full", q.size(), 2);
    i_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_b_valid", b_valid, 0);
    q.delete();
    @(negedge clk) rst_n = 1;
    i_ready = 1;
    @(posedge clk);
    #1;
    send(32'h7FF00093, IMM_I, 8'hB0);
    chk("post_rst_tag", a_tag, 8'hB0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Extends the base I/S/B/U/J immediate decode in four ways:
  - configurable XLEN (32/64), with sign extension to full width;
  - CSR zimm and shift-amount formats;
  - optional RVC (compressed) immediate formats;
  - a valid/ready pipeline stage with a skid buffer, so decode can stall without losing instructions.
- Sits between the fetch/instruction buffer and the decode/issue register; carries a sideband tag alongside the immediate.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- ENABLE_C, 0, 1 enables the RVC immediate formats IMM_CI and IMM_CJ.
- TAG_W, 8, width of the opaque sideband tag (e.g. PC index / ROB id) passed through unchanged.

Ports:
- i_clk  input  1  core clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream has an instruction.
- o_ready  output  1  block can accept an input this cycle.
- i_inst  input  32  instruction word; compressed instructions occupy bits [15:0].
- i_sel  input  imm_ext_t  immediate format select.
- i_tag  input  TAG_W  sideband tag.
- o_valid  output  1  o_imm/o_tag/o_illegal are valid.
- i_ready  input  1  downstream accepts the output this cycle.
- o_imm  output  XLEN  decoded immediate.
- o_tag  output  TAG_W  tag of the output entry.
- o_illegal  output  1  i_sel was unsupported for this configuration.

Behaviour:
- Clocking and reset:
  - One clock domain: i_clk. Reset i_rst_n is asynchronous, active-low.
  - Reset values: o_valid=0, o_ready=1, o_imm=0, o_tag=0, o_illegal=0, skid entry invalid.
- Transfers:
  - Input transfer occurs on i_valid & o_ready.
  - Output transfer occurs on o_valid & i_ready.
- Latency and throughput:
  - An accepted input appears on the outputs on the next rising edge (latency 1).
  - Throughput is 1 per cycle when i_ready is held high.
- Decode, purely combinational before the output/skid registers. S = sign-extend to XLEN, Z = zero-extend.
  - IMM_I: S(inst[31:20]).
  - IMM_S: S({inst[31:25],inst[11:7]}).
  - IMM_B: S({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - IMM_U: S({inst[31:12],12'b0}). For XLEN=64, bits [63:32] copy inst[31].
  - IMM_J: S({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - IMM_Z: Z(inst[19:15]).
  - IMM_SH: Z(inst[25:20]) when XLEN=64; Z(inst[24:20]) when XLEN=32.
  - IMM_CI (ENABLE_C=1): S({inst[12],inst[6:2]}).
  - IMM_CJ (ENABLE_C=1): S({inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],0}).
  - C formats with ENABLE_C=0, or any undefined encoding: o_imm=0, o_illegal=1. The entry is still transferred normally; it is not dropped.
- Skid buffer:
  - Output register plus one skid entry.
  - o_ready is a registered signal equal to !skid_valid.
  - If the output is empty, or is being drained this cycle, the input goes to the output register.
  - If the output is held (o_valid & !i_ready) and an input is accepted, the input goes to the skid entry; o_ready falls the next cycle.
  - When the output drains while the skid is full, the skid moves to the output register and the skid is cleared. A new input is not accepted that cycle because o_ready=0.
  - Order is strictly preserved; no entry is ever dropped or duplicated.
- Output stability: while o_valid & !i_ready, o_imm/o_tag/o_illegal must remain stable.
- Simultaneous drain and accept with an empty skid: the new entry replaces the output register and o_valid stays 1.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronously). Outputs go to their reset values.

Decomposition:
- Add to cotm32_pkg:
  - imm_ext_t enum: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_CI, IMM_CJ; 4-bit.
  - Constant IMM_SEL_W=4.
  - Packed struct imm_entry_t {imm, illegal, tag}, parametrised through module-local typedef.
- Sub-module imm_decode: combinational, params XLEN and ENABLE_C. Inputs inst and sel; outputs imm and illegal.
- imm_gen_pipe instantiates imm_decode and implements the two-register skid control.

Test Plan:
- XLEN=32, i_inst=0xFFF00093, IMM_I, i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_illegal=0.
- i_inst=0xFE000EE3, IMM_B -> o_imm=0xFFFFFFFC. i_inst=0x123450B7, IMM_U -> o_imm=0x12345000.
- XLEN=64: i_inst=0x800000B7, IMM_U -> o_imm=0xFFFFFFFF80000000. Csrrwi with inst[19:15]=5'h1F, IMM_Z -> o_imm=0x1F.
- ENABLE_C=1: i_inst=0x000010FD, IMM_CI -> 0xFFFFFFFF. ENABLE_C=0, same stimulus -> o_imm=0, o_illegal=1, entry delivered.
- Backpressure:
  - Stimulus: tags 1,2,3 presented back-to-back; i_ready=0 for 3 cycles, then 1.
  - Required: tag 2 lands in the skid; o_ready=0 from the next cycle; tag 3 is held upstream; outputs stay stable during the stall.
  - Then tags 1,2,3 emerge in order, with no gaps once i_ready=1.
- Reset mid-operation: assert i_rst_n=0 with output and skid full, between clock edges -> o_valid=0 and o_ready=1 immediately. After release, first output is the first post-reset input.
